// File: rtl/flash_ctrl.sv
// flash_ctrl: entry store for {account, enc_pass} records with a boot-time
// reload scan that replays every valid entry into an external CAM.
//
// Ports:
//   clk, rst        sole clock (rising edge), asynchronous active-high reset
//   wr_req/addr/data  write request, accepted only while idle
//   rd_req/addr       read request, accepted only while idle
//   boot_start        start CAM reload scan, accepted only while idle
//   busy              high whenever the controller is not idle
//   data_flash        registered read / scan data, held between operations
//   rd_valid, rd_miss read result pulse; rd_miss flags an invalid entry
//   cam_write_en/addr one pulse per valid entry during the boot scan
//   boot_done         pulse one cycle after the last scan step
//   entry_count       number of valid entries (0..depth)
//   dbg_state         current FSM state encoding, for observation only
//
// Handshake: requests are level-sampled on the clock edge that ends an idle
// cycle (busy low). Priority is boot_start > wr_req > rd_req; anything not
// taken, and anything asserted while busy, is dropped. Requesters must hold
// off while busy is high. All result outputs are registered single-cycle
// pulses; there is no back-pressure on results.
module flash_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  boot_start,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_flash,
  output logic                  rd_valid,
  output logic                  rd_miss,
  output logic                  cam_write_en,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic                  boot_done,
  output logic [ADDR_WIDTH:0]   entry_count,
  output logic [2:0]            dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_READ     = 3'd2,
    S_BOOT     = 3'd3,
    S_BOOT_END = 3'd4
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] scan_idx;

  // Decoded acceptance in idle, with boot taking precedence over write,
  // and write over read.
  logic take_boot, take_wr, take_rd;
  assign take_boot = (state == S_IDLE) && boot_start;
  assign take_wr   = (state == S_IDLE) && !boot_start && wr_req;
  assign take_rd   = (state == S_IDLE) && !boot_start && !wr_req && rd_req;

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (take_boot)    state_next = S_BOOT;
        else if (take_wr) state_next = S_WRITE;
        else if (take_rd) state_next = S_READ;
      end
      S_WRITE:    state_next = S_IDLE;
      S_READ:     state_next = S_IDLE;
      S_BOOT:     if (scan_idx == LAST_IDX) state_next = S_BOOT_END;
      S_BOOT_END: state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Array contents and captured write data are deliberately not reset;
  // only the valid bits decide whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (take_wr) wr_data_q <= wr_data;
    if (state == S_WRITE) mem[op_addr] <= wr_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      valid          <= '0;
      entry_count    <= '0;
      data_flash     <= '0;
      rd_valid       <= 1'b0;
      rd_miss        <= 1'b0;
      cam_write_en   <= 1'b0;
      cam_write_addr <= '0;
      boot_done      <= 1'b0;
      scan_idx       <= '0;
      op_addr        <= '0;
    end else begin
      state        <= state_next;
      rd_valid     <= 1'b0;
      rd_miss      <= 1'b0;
      cam_write_en <= 1'b0;
      boot_done    <= 1'b0;
      if (take_wr) op_addr <= wr_addr;
      if (take_rd) op_addr <= rd_addr;
      case (state)
        S_WRITE: begin
          valid[op_addr] <= 1'b1;
          if (!valid[op_addr]) entry_count <= entry_count + (ADDR_WIDTH+1)'(1);
        end
        S_READ: begin
          rd_valid   <= 1'b1;
          rd_miss    <= !valid[op_addr];
          data_flash <= valid[op_addr] ? mem[op_addr] : '0;
        end
        S_BOOT: begin
          if (valid[scan_idx]) begin
            cam_write_en   <= 1'b1;
            cam_write_addr <= scan_idx;
            data_flash     <= mem[scan_idx];
          end
          // Wraps back to 0 after the last entry, ready for the next scan.
          scan_idx <= scan_idx + ADDR_WIDTH'(1);
        end
        S_BOOT_END: boot_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
